// File: rtl/stream_demux_1_to_n.sv
// Registered 1-to-N stream demultiplexer: each output channel owns a one-entry
// holding register, so a stalled consumer only blocks beats addressed to it.
module stream_demux_1_to_n #(
  parameter int DATA_W = 8,
  parameter int N_OUT  = 4,
  parameter int SEL_W  = $clog2(N_OUT),
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_bcast,
  output logic [N_OUT-1:0]        out_valid,
  input  logic [N_OUT-1:0]        out_ready,
  output logic [N_OUT*DATA_W-1:0] out_data,
  output logic                    err_sel,
  output logic [CNT_W-1:0]        drop_cnt
);

  // Handshake: a beat moves when valid & ready are both high at a rising edge;
  // valid never waits on ready, and in_ready depends only on select/broadcast
  // and the downstream out_ready, never on in_valid.

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } ch_state_e;

  ch_state_e         state_q [N_OUT];
  ch_state_e         state_d [N_OUT];
  logic [DATA_W-1:0] data_q  [N_OUT];
  logic [N_OUT-1:0]  free;
  logic [N_OUT-1:0]  load;
  logic              sel_ok;
  logic              sel_free;
  logic              fire;
  logic              bad_fire;

  // Input-side decode: channel capacity, ready, and which channels load.
  always_comb begin
    sel_ok   = (int'(in_sel) < N_OUT);
    sel_free = 1'b0;
    for (int k = 0; k < N_OUT; k++) begin
      free[k] = (state_q[k] == EMPTY) | out_ready[k];
      if (int'(in_sel) == k) sel_free = free[k];
    end
    if (in_bcast)    in_ready = &free;
    else if (sel_ok) in_ready = sel_free;
    else             in_ready = 1'b1;
    fire     = in_valid & in_ready;
    bad_fire = fire & ~in_bcast & ~sel_ok;
    for (int k = 0; k < N_OUT; k++) begin
      load[k] = fire & (in_bcast | (int'(in_sel) == k));
    end
  end

  // Channel FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_OUT; k++) state_q[k] <= EMPTY;
    end else begin
      for (int k = 0; k < N_OUT; k++) state_q[k] <= state_d[k];
    end
  end

  // Channel FSM next state; a load wins over a drain so a reload leaves no bubble.
  always_comb begin
    for (int k = 0; k < N_OUT; k++) begin
      state_d[k] = state_q[k];
      if (load[k])                                    state_d[k] = FULL;
      else if (state_q[k] == FULL && out_ready[k])    state_d[k] = EMPTY;
    end
  end

  // Channel FSM outputs.
  always_comb begin
    out_valid = '0;
    out_data  = '0;
    for (int k = 0; k < N_OUT; k++) begin
      out_valid[k]                  = (state_q[k] == FULL);
      out_data[k*DATA_W +: DATA_W]  = data_q[k];
    end
  end

  // Payload registers keep their value after a drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_OUT; k++) data_q[k] <= '0;
    end else begin
      for (int k = 0; k < N_OUT; k++) begin
        if (load[k]) data_q[k] <= in_data;
      end
    end
  end

  // Bad-select reporting: one-cycle pulse plus a saturating drop counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sel  <= 1'b0;
      drop_cnt <= '0;
    end else begin
      err_sel <= bad_fire;
      if (bad_fire && drop_cnt != {CNT_W{1'b1}}) drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_stream_demux_1_to_n.sv
// Bench for stream_demux_1_to_n: a 4-channel instance plus two 3-channel
// instances (CNT_W 2 and 16) sharing stimulus for the bad-select cases.
module tb_stream_demux_1_to_n;

  logic        clk;
  logic        rst_n;

  // 4-channel DUT
  logic        in_valid, in_ready, in_bcast;
  logic [7:0]  in_data;
  logic [1:0]  in_sel;
  logic [3:0]  out_valid, out_ready;
  logic [31:0] out_data;
  logic        err_sel;
  logic [15:0] drop_cnt;

  // 3-channel DUTs, shared inputs
  logic        b_valid, b_bcast;
  logic [7:0]  b_data;
  logic [1:0]  b_sel;
  logic [2:0]  b_oready;
  logic        b_in_ready, c_in_ready;
  logic [2:0]  b_out_valid, c_out_valid;
  logic [23:0] b_out_data, c_out_data;
  logic        b_err_sel, c_err_sel;
  logic [1:0]  b_drop_cnt;
  logic [15:0] c_drop_cnt;

  int n_vec  = 0;
  int n_fail = 0;

  stream_demux_1_to_n #(.DATA_W(8), .N_OUT(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .in_bcast(in_bcast),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .err_sel(err_sel), .drop_cnt(drop_cnt)
  );

  stream_demux_1_to_n #(.DATA_W(8), .N_OUT(3), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_valid), .in_ready(b_in_ready),
    .in_data(b_data), .in_sel(b_sel), .in_bcast(b_bcast),
    .out_valid(b_out_valid), .out_ready(b_oready), .out_data(b_out_data),
    .err_sel(b_err_sel), .drop_cnt(b_drop_cnt)
  );

  stream_demux_1_to_n #(.DATA_W(8), .N_OUT(3), .CNT_W(16)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(b_valid), .in_ready(c_in_ready),
    .in_data(b_data), .in_sel(b_sel), .in_bcast(b_bcast),
    .out_valid(c_out_valid), .out_ready(b_oready), .out_data(c_out_data),
    .err_sel(c_err_sel), .drop_cnt(c_drop_cnt)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] d, input logic [1:0] s, input logic b);
    in_valid = 1'b1;
    in_data  = d;
    in_sel   = s;
    in_bcast = b;
  endtask

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q [4][$];
  bit         sb_on     = 1'b0;
  bit         stream_on = 1'b0;
  bit         load3_prev = 1'b0;

  always @(negedge clk) begin
    if (sb_on && rst_n) begin
      for (int k = 0; k < 4; k++) begin
        if (out_valid[k] && out_ready[k]) begin
          if (exp_q[k].size() == 0) begin
            check($sformatf("sb_unexpected_ch%0d", k), 32'(out_data[k*8 +: 8]), 32'hxx);
          end else begin
            check($sformatf("sb_data_ch%0d", k), 32'(out_data[k*8 +: 8]), 32'(exp_q[k].pop_front()));
          end
        end
      end
      if (stream_on) check("no_bubble_ch3", 32'(out_valid[3]), 32'(load3_prev));
      load3_prev = in_valid && in_ready && (in_bcast || in_sel == 2'd3);
      if (in_valid && in_ready) begin
        for (int k = 0; k < 4; k++) begin
          if (in_bcast || int'(in_sel) == k) exp_q[k].push_back(in_data);
        end
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0] data;
    logic [1:0] sel;
    logic       bcast;
    logic [3:0] exp_valid;
  } vec_t;

  vec_t vt[6];

  initial begin
    vt[0] = '{data: 8'hA5, sel: 2'd2, bcast: 1'b0, exp_valid: 4'b0100};
    vt[1] = '{data: 8'h3C, sel: 2'd0, bcast: 1'b0, exp_valid: 4'b0001};
    vt[2] = '{data: 8'hC3, sel: 2'd1, bcast: 1'b0, exp_valid: 4'b0010};
    vt[3] = '{data: 8'hFF, sel: 2'd3, bcast: 1'b0, exp_valid: 4'b1000};
    vt[4] = '{data: 8'h5A, sel: 2'd1, bcast: 1'b1, exp_valid: 4'b1111};
    vt[5] = '{data: 8'h00, sel: 2'd2, bcast: 1'b0, exp_valid: 4'b0100};

    rst_n = 1'b0;
    in_valid = 1'b0; in_data = '0; in_sel = '0; in_bcast = 1'b0; out_ready = 4'hF;
    b_valid = 1'b0; b_data = '0; b_sel = '0; b_bcast = 1'b0; b_oready = 3'b111;

    // Reset values before any clock edge
    #3;
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'h0);
    check("rst_err_sel", 32'(err_sel), 32'h0);
    check("rst_out_data", out_data, 32'h0);
    #9 rst_n = 1'b1;
    tick();
    sb_on = 1'b1;

    // Table-driven single beats, all consumers ready
    for (int i = 0; i < 6; i++) begin
      drive(vt[i].data, vt[i].sel, vt[i].bcast);
      @(negedge clk);
      check($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'h1);
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      check($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vt[i].exp_valid));
      for (int k = 0; k < 4; k++) begin
        if (vt[i].exp_valid[k])
          check($sformatf("vec%0d_data_ch%0d", i, k), 32'(out_data[k*8 +: 8]), 32'(vt[i].data));
      end
      tick();
      @(negedge clk);
      check($sformatf("vec%0d_drained", i), 32'(out_valid), 32'h0);
      tick();
    end

    // Backpressure on channel 1
    out_ready = 4'b1101;
    drive(8'h11, 2'd1, 1'b0);
    @(negedge clk);
    check("bp_first_ready", 32'(in_ready), 32'h1);
    tick();
    drive(8'h22, 2'd1, 1'b0);
    @(negedge clk);
    check("bp_stall", 32'(in_ready), 32'h0);
    check("bp_ch1_held", 32'(out_data[15:8]), 32'h11);
    tick();
    @(negedge clk);
    check("bp_stall2", 32'(in_ready), 32'h0);
    check("bp_ch1_valid", 32'(out_valid), 32'b0010);
    tick();
    drive(8'h33, 2'd0, 1'b0);
    @(negedge clk);
    check("bp_other_ready", 32'(in_ready), 32'h1);
    tick();
    drive(8'h22, 2'd1, 1'b0);
    @(negedge clk);
    check("bp_other_delivered", 32'(out_valid), 32'b0011);
    check("bp_ch0_data", 32'(out_data[7:0]), 32'h33);
    check("bp_still_stalled", 32'(in_ready), 32'h0);
    tick();
    out_ready = 4'hF;
    @(negedge clk);
    check("bp_release_ready", 32'(in_ready), 32'h1);
    check("bp_first_out", 32'(out_data[15:8]), 32'h11);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_second_valid", 32'(out_valid[1]), 32'h1);
    check("bp_second_out", 32'(out_data[15:8]), 32'h22);
    tick();
    @(negedge clk);
    check("bp_empty", 32'(out_valid), 32'h0);
    tick();

    // Broadcast blocked by one full channel
    out_ready = 4'b1110;
    drive(8'h77, 2'd0, 1'b0);
    @(negedge clk);
    check("bc_fill_ready", 32'(in_ready), 32'h1);
    tick();
    drive(8'h5C, 2'd0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("bc_blocked", 32'(in_ready), 32'h0);
      check("bc_no_partial", 32'(out_valid), 32'b0001);
      tick();
    end
    out_ready = 4'hF;
    @(negedge clk);
    check("bc_release_ready", 32'(in_ready), 32'h1);
    tick();
    in_valid = 1'b0;
    in_bcast = 1'b0;
    @(negedge clk);
    check("bc_all_valid", 32'(out_valid), 32'hF);
    check("bc_all_data", out_data, 32'h5C5C5C5C);
    tick();
    @(negedge clk);
    check("bc_empty", 32'(out_valid), 32'h0);
    tick();

    // Bad select on the 3-channel instances
    b_valid = 1'b1;
    b_sel   = 2'd3;
    for (int i = 0; i < 5; i++) begin
      b_data = 8'(i + 1);
      @(negedge clk);
      check("bad_in_ready", 32'(b_in_ready), 32'h1);
      check("bad_no_valid", 32'(c_out_valid), 32'h0);
      check("bad_cnt_running", 32'(c_drop_cnt), 32'(i));
      if (i > 0) check("bad_err_pulse", 32'(c_err_sel), 32'h1);
      tick();
    end
    b_valid = 1'b0;
    @(negedge clk);
    check("bad_err_last", 32'(b_err_sel), 32'h1);
    check("bad_drop_cnt16", 32'(c_drop_cnt), 32'd5);
    check("bad_drop_sat", 32'(b_drop_cnt), 32'd3);
    check("bad_no_valid_b", 32'(b_out_valid), 32'h0);
    tick();
    @(negedge clk);
    check("bad_err_clear", 32'(b_err_sel), 32'h0);
    tick();
    b_valid = 1'b1;
    b_sel   = 2'd2;
    b_data  = 8'h42;
    @(negedge clk);
    check("good_b_ready", 32'(b_in_ready), 32'h1);
    tick();
    b_valid = 1'b0;
    @(negedge clk);
    check("good_b_valid", 32'(b_out_valid), 32'b100);
    check("good_b_data", 32'(b_out_data[23:16]), 32'h42);
    check("good_b_no_err", 32'(b_err_sel), 32'h0);
    check("good_b_cnt_hold", 32'(b_drop_cnt), 32'd3);
    tick();

    // Random streaming, channel 3 always ready
    stream_on = 1'b1;
    for (int n = 0; n < 256; n++) begin
      bit fired;
      int guard;
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        out_ready[2:0] = 3'($urandom_range(0, 7));
        tick();
      end
      drive(8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0));
      fired = 1'b0;
      guard = 0;
      while (!fired) begin
        @(negedge clk);
        fired = in_ready;
        tick();
        out_ready[2:0] = 3'($urandom_range(0, 7));
        guard++;
        if (guard > 200) begin
          check("stream_accept_timeout", 32'(fired), 32'h1);
          break;
        end
      end
    end
    in_valid = 1'b0;
    in_bcast = 1'b0;
    out_ready = 4'hF;
    repeat (4) tick();
    stream_on = 1'b0;
    for (int k = 0; k < 4; k++) check($sformatf("sb_empty_ch%0d", k), 32'(exp_q[k].size()), 32'h0);

    // Reset while a beat is held
    sb_on = 1'b0;
    out_ready = 4'b1011;
    drive(8'h99, 2'd2, 1'b0);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("mid_loaded", 32'(out_valid), 32'b0100);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'h0);
    check("mid_rst_data", out_data, 32'h0);
    check("mid_rst_drop", 32'(c_drop_cnt), 32'h0);
    check("mid_rst_drop_b", 32'(b_drop_cnt), 32'h0);
    #4 rst_n = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
